// File: rtl/rv32_isa_pkg.sv
// RV32I field positions, opcode values and operand-use decode shared by the
// issue controller and its scoreboard.
package rv32_isa_pkg;

    localparam int XLEN    = 32;
    localparam int REG_W   = 5;
    localparam int NREGS   = 32;
    localparam int CNT_W   = 4;
    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 7;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic wr_rd;
        logic illegal;
    } op_use_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic            illegal;
    } iss_entry_t;

    function automatic op_use_t decode_use(input logic [OPC_W-1:0] opc);
        op_use_t u;
        u = '0;
        case (opc)
            OP_R:                        begin u.use_rs1 = 1'b1; u.use_rs2 = 1'b1; u.wr_rd = 1'b1; end
            OP_IMM, OP_LOAD, OP_JALR:    begin u.use_rs1 = 1'b1; u.wr_rd = 1'b1; end
            OP_STORE, OP_BRANCH:         begin u.use_rs1 = 1'b1; u.use_rs2 = 1'b1; end
            OP_LUI, OP_AUIPC, OP_JAL:    u.wr_rd = 1'b1;
            default:                     u.illegal = 1'b1;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits plus the count of outstanding rd-writers.
// x0 is hardwired idle; a set and clear of the same register leaves it set.
module reg_scoreboard
    import rv32_isa_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    output logic [NREGS-1:0] busy,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);

    logic             set_hit;
    logic             clr_hit;
    logic             clr_miss;
    logic [NREGS-1:0] busy_next;

    assign set_hit  = set_en & (set_idx != '0);
    assign clr_hit  = clr_en & (clr_idx != '0) & busy[clr_idx];
    assign clr_miss = clr_en & (clr_idx != '0) & ~busy[clr_idx];

    // Clear before set so a same-cycle re-allocation keeps the new owner.
    always_comb begin
        busy_next = busy;
        if (clr_hit) busy_next[clr_idx] = 1'b0;
        if (set_hit) busy_next[set_idx] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else if (flush) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            busy <= busy_next;
            case ({set_hit, clr_hit})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (clr_miss) err <= 1'b1;
        end
    end

endmodule

// File: rtl/issue_scoreboard_ctrl.sv
// Issue controller: decodes operand use, blocks on RAW/WAW hazards and the
// outstanding-writer limit, and issues through a one-entry output register.
module issue_scoreboard_ctrl
    import rv32_isa_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        iss_valid,
    input  logic        iss_ready,
    output logic [31:0] iss_instr,
    output logic        iss_illegal,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    output logic [31:0] busy_o,
    output logic        err_wb
);

    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    op_use_t          ou;

    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] wb_mask;
    logic [NREGS-1:0] beff;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next_base;
    logic             wb_dec;
    logic             wr_rd_nz;
    logic             hazard;
    logic             at_max;
    logic             accept;
    iss_entry_t       out_q;
    logic             out_vld;

    assign opcode   = in_instr[OPC_LSB +: OPC_W];
    assign rd       = in_instr[RD_LSB  +: REG_W];
    assign rs1      = in_instr[RS1_LSB +: REG_W];
    assign rs2      = in_instr[RS2_LSB +: REG_W];
    assign ou       = decode_use(opcode);
    assign wr_rd_nz = ou.wr_rd & (rd != '0);

    // A writeback landing this cycle releases its register for the incoming word.
    assign wb_mask = wb_valid ? (NREGS'(1) << wb_rd) : '0;
    assign beff    = busy & ~wb_mask;
    assign hazard  = (ou.use_rs1 & beff[rs1]) | (ou.use_rs2 & beff[rs2]) | (ou.wr_rd & beff[rd]);

    assign wb_dec        = wb_valid & (wb_rd != '0) & busy[wb_rd];
    assign cnt_next_base = cnt - {{(CNT_W-1){1'b0}}, wb_dec};
    assign at_max        = wr_rd_nz & (cnt_next_base == CNT_W'(MAX_OUTSTANDING));

    assign in_ready = ~flush & (~out_vld | iss_ready) & ~hazard & ~at_max;
    assign accept   = in_valid & in_ready;

    reg_scoreboard u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .set_en  (accept & wr_rd_nz),
        .set_idx (rd),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .busy    (busy),
        .cnt     (cnt),
        .err     (err_wb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (flush) begin
            out_vld <= 1'b0;
        end else if (accept) begin
            out_vld       <= 1'b1;
            out_q.instr   <= in_instr;
            out_q.illegal <= ou.illegal;
        end else if (iss_ready) begin
            out_vld <= 1'b0;
        end
    end

    assign iss_valid   = out_vld;
    assign iss_instr   = out_q.instr;
    assign iss_illegal = out_q.illegal;
    assign busy_o      = busy;

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Bench for issue_scoreboard_ctrl: directed vector table, async reset checks
// and randomized traffic against a register-set reference model.
module tb_issue_scoreboard_ctrl;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        iss_valid;
    logic        iss_ready = 1'b0;
    logic [31:0] iss_instr;
    logic        iss_illegal;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] busy_o;
    logic        err_wb;

    int checks = 0;
    int failures = 0;

    // Reference state: set of registers with a pending write, output slot, sticky error.
    bit [31:0]   m_busy;
    bit          m_ival;
    logic [31:0] m_instr;
    bit          m_ill;
    bit          m_err;

    always #5 clk = ~clk;

    issue_scoreboard_ctrl #(.MAX_OUTSTANDING(MAX)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_instr(iss_instr),
        .iss_illegal(iss_illegal), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .busy_o(busy_o), .err_wb(err_wb)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_r(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] mk_i(input int rd, input int rs1);
        return {12'h001, 5'(rs1), 3'd0, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] mk_s(input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd4, 7'b0100011};
    endfunction
    function automatic logic [31:0] mk_lui(input int rd);
        return {20'h12345, 5'(rd), 7'b0110111};
    endfunction

    function automatic void uses(input logic [6:0] op, output bit u1, output bit u2,
                                 output bit w, output bit ill);
        u1 = 0; u2 = 0; w = 0; ill = 0;
        case (op)
            7'b0110011: begin u1 = 1; u2 = 1; w = 1; end
            7'b0010011, 7'b0000011, 7'b1100111: begin u1 = 1; w = 1; end
            7'b0100011, 7'b1100011: begin u1 = 1; u2 = 1; end
            7'b0110111, 7'b0010111, 7'b1101111: w = 1;
            default: ill = 1;
        endcase
    endfunction

    function automatic bit model_ready(input bit fl, input logic [31:0] ins, input bit ir,
                                       input bit wv, input logic [4:0] wr);
        bit u1, u2, w, ill, haz;
        bit [31:0] pend;
        uses(ins[6:0], u1, u2, w, ill);
        pend = m_busy;
        if (wv) pend[wr] = 1'b0;
        haz = (u1 && pend[ins[19:15]]) || (u2 && pend[ins[24:20]]) || (w && pend[ins[11:7]]);
        return !fl && (!m_ival || ir) && !haz && !(w && ins[11:7] != 0 && $countones(pend) == MAX);
    endfunction

    function automatic void model_step(input bit fl, input bit iv, input logic [31:0] ins,
                                       input bit ir, input bit wv, input logic [4:0] wr,
                                       input bit rdy);
        bit u1, u2, w, ill;
        if (fl) begin
            m_busy = '0;
            m_ival = 0;
            return;
        end
        uses(ins[6:0], u1, u2, w, ill);
        if (wv && wr != 0) begin
            if (m_busy[wr]) m_busy[wr] = 1'b0;
            else m_err = 1'b1;
        end
        if (iv && rdy) begin
            m_instr = ins;
            m_ill   = ill;
            m_ival  = 1;
            if (w && ins[11:7] != 0) m_busy[ins[11:7]] = 1'b1;
        end else if (ir) begin
            m_ival = 0;
        end
    endfunction

    function automatic void model_reset();
        m_busy = '0; m_ival = 0; m_instr = '0; m_ill = 0; m_err = 0;
    endfunction

    // Called just after a falling edge: drive, check in_ready, clock once, check state.
    task automatic apply(input bit fl, input bit iv, input logic [31:0] ins, input bit ir,
                         input bit wv, input logic [4:0] wr, output logic rdy_act);
        bit rdy_m;
        flush = fl; in_valid = iv; in_instr = ins; iss_ready = ir; wb_valid = wv; wb_rd = wr;
        #1;
        rdy_m   = model_ready(fl, ins, ir, wv, wr);
        rdy_act = in_ready;
        chk("model_in_ready", {31'd0, in_ready}, {31'd0, rdy_m});
        model_step(fl, iv, ins, ir, wv, wr, rdy_m);
        @(negedge clk);
        chk("model_busy", busy_o, m_busy);
        chk("model_iss_valid", {31'd0, iss_valid}, {31'd0, m_ival});
        chk("model_err_wb", {31'd0, err_wb}, {31'd0, m_err});
        if (m_ival) begin
            chk("model_iss_instr", iss_instr, m_instr);
            chk("model_iss_illegal", {31'd0, iss_illegal}, {31'd0, m_ill});
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_iss_valid"}, {31'd0, iss_valid}, 32'd0);
        chk({tag, "_iss_instr"}, iss_instr, 32'd0);
        chk({tag, "_iss_illegal"}, {31'd0, iss_illegal}, 32'd0);
        chk({tag, "_busy"}, busy_o, 32'd0);
        chk({tag, "_err_wb"}, {31'd0, err_wb}, 32'd0);
    endtask

    typedef struct {
        bit          fl, iv;
        logic [31:0] ins;
        bit          ir, wv;
        logic [4:0]  wr;
        bit          rdy;
        logic [31:0] busy;
        bit          ival, err;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input bit fl, input bit iv, input logic [31:0] ins, input bit ir,
                        input bit wv, input int wr, input bit rdy, input logic [31:0] busy,
                        input bit ival, input bit err);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ins = ins; v.ir = ir; v.wv = wv; v.wr = 5'(wr);
        v.rdy = rdy; v.busy = busy; v.ival = ival; v.err = err;
        tbl.push_back(v);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [10];
        logic [31:0] r;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1111111};
        r = $urandom;
        r[6:0]   = ops[$urandom_range(0, 9)];
        r[11:7]  = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[24:20] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    initial begin
        logic r_act;
        logic [4:0] wr;
        // fl iv instr ir wv wr | ready busy ival err
        addv(0, 1, mk_r(6, 21, 5), 1, 0, 0,  1, 32'h40,  1, 0);
        addv(0, 1, mk_r(7, 6, 1),  1, 0, 0,  0, 32'h40,  0, 0);
        addv(0, 1, mk_r(7, 6, 1),  1, 1, 6,  1, 32'h80,  1, 0);
        addv(0, 0, 32'd0,          1, 1, 7,  1, 32'h0,   0, 0);
        addv(0, 1, mk_i(1, 0),     1, 0, 0,  1, 32'h2,   1, 0);
        addv(0, 1, mk_i(2, 0),     1, 0, 0,  1, 32'h6,   1, 0);
        addv(0, 1, mk_i(3, 0),     1, 0, 0,  1, 32'hE,   1, 0);
        addv(0, 1, mk_i(4, 0),     1, 0, 0,  1, 32'h1E,  1, 0);
        addv(0, 1, mk_i(5, 0),     1, 0, 0,  0, 32'h1E,  0, 0);
        addv(0, 1, mk_s(9, 10),    1, 0, 0,  1, 32'h1E,  1, 0);
        addv(0, 1, mk_i(5, 0),     1, 1, 1,  1, 32'h3C,  1, 0);
        addv(0, 1, mk_s(9, 10),    0, 0, 0,  0, 32'h3C,  1, 0);
        addv(0, 1, mk_s(9, 10),    0, 0, 0,  0, 32'h3C,  1, 0);
        addv(0, 1, mk_s(9, 10),    0, 0, 0,  0, 32'h3C,  1, 0);
        addv(0, 1, mk_s(9, 10),    1, 0, 0,  1, 32'h3C,  1, 0);
        addv(0, 1, mk_lui(0),      1, 0, 0,  1, 32'h3C,  1, 0);
        addv(0, 0, 32'd0,          1, 1, 10, 1, 32'h3C,  0, 1);
        addv(0, 0, 32'd0,          1, 1, 0,  1, 32'h3C,  0, 1);
        addv(0, 1, mk_i(9, 0),     1, 1, 2,  1, 32'h238, 1, 1);
        addv(1, 1, mk_i(11, 0),    1, 1, 3,  0, 32'h0,   0, 1);
        addv(0, 1, mk_i(2, 0),     1, 0, 0,  1, 32'h4,   1, 1);

        model_reset();
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].fl, tbl[i].iv, tbl[i].ins, tbl[i].ir, tbl[i].wv, tbl[i].wr, r_act);
            chk($sformatf("vec%0d_in_ready", i), {31'd0, r_act}, {31'd0, tbl[i].rdy});
            chk($sformatf("vec%0d_busy", i), busy_o, tbl[i].busy);
            chk($sformatf("vec%0d_iss_valid", i), {31'd0, iss_valid}, {31'd0, tbl[i].ival});
            chk($sformatf("vec%0d_err_wb", i), {31'd0, err_wb}, {31'd0, tbl[i].err});
        end

        // Build a multi-entry burst, then drop reset between clock edges.
        apply(0, 1, mk_i(1, 0), 1, 0, 0, r_act);
        apply(0, 1, mk_i(3, 0), 0, 0, 0, r_act);
        apply(0, 0, 32'd0, 1, 1, 20, r_act);
        apply(0, 1, mk_i(5, 0), 0, 0, 0, r_act);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        flush = 0; in_valid = 0; wb_valid = 0; iss_ready = 0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 1500; n++) begin
            wr = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 8) begin
                for (int k = 0; k < 8; k++) begin
                    wr = 5'($urandom_range(1, 7));
                    if (m_busy[wr]) break;
                end
            end
            if (n == 750) begin
                #3 rst_n = 1'b0;
                #1;
                chk_all_zero("rand_rst");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            apply($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, rand_instr(),
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, wr, r_act);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
